jk_bank_sequencer: RTL

//  Command-driven sequencer for a WIDTH-bit bank of JK flip-flops. The bank
//   is held internally and uses standard JK encoding:
//   00 = hold, 01 = clear, 10 = set, 11 = toggle.

---
 rtl/jk_bank_sequencer_if.sv | 28 ++
 rtl/jk_bank_sequencer.sv | 107 ++++++++++
 2 files changed

// File: rtl/jk_bank_sequencer_if.sv
// Command handshake and bank observation bundle for jk_bank_sequencer.
// Host drives the command fields; the sequencer reports bank state and status.
interface jk_bank_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] jk_j;
  logic [WIDTH-1:0] jk_k;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output cmd_valid, cmd_op, cmd_mask, cmd_count,
    input  cmd_ready, q, jk_j, jk_k, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mask, cmd_count,
    output cmd_ready, q, jk_j, jk_k, busy, done, err
  );
endinterface

// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer owning a bank of JK flip-flops.
// Masked clear/set/toggle or up/down count runs, one command at a time.
module jk_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                rst,
  jk_bank_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    COUNT,
    DONE
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [CNT_W-1:0] rem;
  logic             accept;
  logic             in_cnt;
  logic             down;
  logic             run;

  assign bus.cmd_ready = (state == IDLE) & ~rst;
  assign accept = bus.cmd_valid & bus.cmd_ready;
  assign in_cnt = (bus.cmd_op == 3'd4) | (bus.cmd_op == 3'd5);
  assign down = (op_r == 3'd5);

  always_comb begin
    nxt = state;
    j   = '0;
    k   = '0;
    run = 1'b1;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!in_cnt)
            nxt = APPLY;
          else if (bus.cmd_count != '0)
            nxt = COUNT;
          else
            nxt = DONE;
        end
      end
      APPLY: begin
        unique case (1'b1)
          (op_r == 3'd1): k = mask_r;
          (op_r == 3'd2): j = mask_r;
          (op_r == 3'd3): begin
            j = mask_r;
            k = mask_r;
          end
          default: ;
        endcase
        nxt = DONE;
      end
      COUNT: begin
        // Ripple carry/borrow: bit i toggles when all lower bits are 1 (0).
        for (int i = 0; i < WIDTH; i++) begin
          j[i] = run;
          k[i] = run;
          run  = down ? (run & ~q_r[i]) : (run & q_r[i]);
        end
        if (rem == CNT_W'(1))
          nxt = DONE;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      q_r    <= '0;
      op_r   <= '0;
      mask_r <= '0;
      rem    <= '0;
    end else begin
      state <= nxt;
      q_r   <= (j & ~q_r) | (~k & q_r);
      if (accept) begin
        op_r   <= bus.cmd_op;
        mask_r <= bus.cmd_mask;
        rem    <= bus.cmd_count;
      end else if (state == COUNT) begin
        rem <= rem - CNT_W'(1);
      end
    end
  end

  assign bus.q    = q_r;
  assign bus.jk_j = j;
  assign bus.jk_k = k;
  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.err  = (state == DONE) & op_r[2] & op_r[1];

endmodule
